// File: rtl/if_prefetch_buf_if.sv
// Handshake bundle for the IF-stage prefetch buffer.
//   master : the prefetch buffer (drives the memory request and the IF/ID head fields)
//   slave  : the environment (instruction memory, ID redirect, IF/ID consumer)
// Signals:
//   redirect, redirect_pc            ID -> buffer, flush and restart fetch
//   imem_req, imem_addr              buffer -> memory, fetch request
//   imem_gnt, imem_rvalid, imem_rdata memory -> buffer, accept and in-order response
//   inst_valid, inst_out, pc_out, npc_out  buffer -> IF/ID, FIFO head
//   inst_take                        IF/ID -> buffer, pop head
interface if_prefetch_buf_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic [31:0] npc_out;
    logic        inst_take;

    modport master (
        input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_take,
        output imem_req, imem_addr, inst_valid, inst_out, pc_out, npc_out
    );

    modport slave (
        output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_take,
        input  imem_req, imem_addr, inst_valid, inst_out, pc_out, npc_out
    );
endinterface

// File: rtl/if_prefetch_buf.sv
// Instruction prefetch buffer for the IF stage.
// Fetches sequential words ahead of the pipeline from a variable-latency memory port into a
// small FIFO, tags each word with its PC, and presents {instruction, pc, pc+4} to IF/ID.
// A redirect from ID flushes the FIFO and marks every in-flight request stale so that its
// response is dropped when it eventually returns.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous, active-high reset
//   bus    : if_prefetch_buf_if.master (memory request/response, redirect, IF/ID head)
// Parameters:
//   DEPTH    : FIFO entries, power of two, >= 2
//   MAX_OUT  : max accepted-but-unanswered memory requests, 1..DEPTH
//   RESET_PC : first fetch address after reset
module if_prefetch_buf #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                clock,
    input logic                reset,
    if_prefetch_buf_if.master  bus
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned OutW = $clog2(MAX_OUT + 1);

    localparam logic [CntW:0]   DepthV  = (CntW + 1)'(DEPTH);
    localparam logic [OutW-1:0] MaxOutV = OutW'(MAX_OUT);

    // State
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     resp_pc_q,  resp_pc_d;
    logic [CntW-1:0] count_q,    count_d;
    logic [OutW-1:0] outst_q,    outst_d;
    logic [OutW-1:0] discard_q,  discard_d;
    logic [PtrW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q,   wr_ptr_d;

    logic [31:0] inst_mem_q [DEPTH];
    logic [31:0] pc_mem_q   [DEPTH];

    // Per-cycle events
    logic          occ_ok;
    logic          accept;
    logic          rsp;
    logic          rsp_drop;
    logic          push;
    logic          pop;
    logic [CntW:0] occupancy;
    logic [OutW-1:0] discard_eff;

    // Every slot that is either filled or promised to an in-flight response counts against
    // DEPTH, so a response can always be pushed without checking for a full FIFO.
    always_comb begin
        occupancy = {1'b0, count_q} + (CntW + 1)'(outst_q);
        occ_ok    = (occupancy < DepthV) && (outst_q < MaxOutV);
    end

    always_comb begin
        bus.imem_req  = !reset && !bus.redirect && occ_ok;
        bus.imem_addr = fetch_pc_q;
    end

    // A response with nothing outstanding is a protocol error and is ignored.
    always_comb begin
        accept   = bus.imem_req & bus.imem_gnt;
        rsp      = bus.imem_rvalid & (outst_q != '0);
        rsp_drop = rsp & (discard_q != '0);
        push     = rsp & ~rsp_drop & ~bus.redirect;
        pop      = (count_q != '0) & bus.inst_take & ~bus.redirect;
    end

    // Head fields come straight from storage; storage is cleared on reset so the head reads
    // as inst 0 / pc 0 / npc 4 while reset is held.
    always_comb begin
        bus.inst_valid = (count_q != '0);
        bus.inst_out   = inst_mem_q[rd_ptr_q];
        bus.pc_out     = pc_mem_q[rd_ptr_q];
        bus.npc_out    = pc_mem_q[rd_ptr_q] + 32'd4;
    end

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        resp_pc_d   = resp_pc_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        outst_d     = outst_q + OutW'(accept) - OutW'(rsp);
        discard_eff = discard_q - OutW'(rsp_drop);
        discard_d   = discard_eff;

        if (bus.redirect) begin
            // imem_req is low during a redirect, so no accept can happen this cycle. Every
            // request still in flight after this cycle's response belongs to the old stream:
            // the already-stale ones (discard_eff) plus the ones that were going to be kept.
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = bus.redirect_pc;
            resp_pc_d  = bus.redirect_pc;
            discard_d  = outst_d;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (push) begin
                wr_ptr_d  = wr_ptr_q + 1'b1;
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else if (push) begin
            inst_mem_q[wr_ptr_q] <= bus.imem_rdata;
            pc_mem_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

    // Simulation-only protocol and invariant checks.
    rvalid_without_outstanding: assert property (
        @(posedge clock) disable iff (reset) bus.imem_rvalid |-> (outst_q != '0)
    );

    discard_within_outstanding: assert property (
        @(posedge clock) disable iff (reset) discard_q <= outst_q
    );

    occupancy_within_depth: assert property (
        @(posedge clock) disable iff (reset) occupancy <= DepthV
    );

endmodule

// File: tb/tb_if_prefetch_buf.sv
module tb_if_prefetch_buf;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    if_prefetch_buf_if bus ();

    if_prefetch_buf #(
        .DEPTH    (DEPTH),
        .MAX_OUT  (MAX_OUT),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    endtask

    // Instruction memory contents: a bijective scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Reference model: requests in flight (in order) and the PCs of buffered words.
    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } req_t;

    req_t        inflight[$];
    logic [31:0] fifo_pc[$];
    logic [31:0] m_fetch_pc;
    bit          exp_req;

    function automatic logic [31:0] pick_redirect_pc();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFFC;
            1:       return 32'h0000_0100;
            default: return {16'h0, $urandom_range(0, 16'hFFFF)} & 32'hFFFF_FFFC;
        endcase
    endfunction

    task automatic drive(input int p_gnt, input int p_rv, input int p_take, input int p_redir);
        bus.imem_gnt    = ($urandom_range(0, 99) < p_gnt);
        bus.imem_rvalid = (inflight.size() > 0) && ($urandom_range(0, 99) < p_rv);
        bus.imem_rdata  = bus.imem_rvalid ? mem_word(inflight[0].addr) : $urandom;
        bus.inst_take   = ($urandom_range(0, 99) < p_take);
        bus.redirect    = ($urandom_range(0, 99) < p_redir);
        bus.redirect_pc = pick_redirect_pc();
    endtask

    task automatic check_outputs();
        exp_req = !bus.redirect && (fifo_pc.size() + inflight.size() < DEPTH)
                  && (inflight.size() < MAX_OUT);
        check("imem_req",   32'(bus.imem_req),   32'(exp_req));
        check("imem_addr",  bus.imem_addr,       m_fetch_pc);
        check("inst_valid", 32'(bus.inst_valid), 32'(fifo_pc.size() != 0));
        if (fifo_pc.size() != 0) begin
            check("inst_out", bus.inst_out, mem_word(fifo_pc[0]));
            check("pc_out",   bus.pc_out,   fifo_pc[0]);
            check("npc_out",  bus.npc_out,  fifo_pc[0] + 32'd4);
        end
        check("count_bound",   32'(dut.count_q <= DEPTH),        32'd1);
        check("outst_bound",   32'(dut.outst_q <= MAX_OUT),      32'd1);
        check("discard_bound", 32'(dut.discard_q <= dut.outst_q), 32'd1);
    endtask

    task automatic update_model();
        bit   acc;
        bit   rsp;
        bit   do_pop;
        req_t e;
        acc    = exp_req && bus.imem_gnt;
        rsp    = bus.imem_rvalid && (inflight.size() > 0);
        do_pop = !bus.redirect && bus.inst_take && (fifo_pc.size() > 0);
        if (do_pop) void'(fifo_pc.pop_front());
        if (rsp) begin
            e = inflight.pop_front();
            if (!e.stale && !bus.redirect) fifo_pc.push_back(e.addr);
        end
        if (bus.redirect) begin
            fifo_pc.delete();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            m_fetch_pc = bus.redirect_pc;
        end else if (acc) begin
            inflight.push_back('{addr: m_fetch_pc, stale: 1'b0});
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
    endtask

    task automatic run_phase(input int cycles, input int p_gnt, input int p_rv,
                             input int p_take, input int p_redir);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clock);
            #1;
            drive(p_gnt, p_rv, p_take, p_redir);
            #4;
            check_outputs();
            update_model();
        end
    endtask

    task automatic model_reset();
        inflight.delete();
        fifo_pc.delete();
        m_fetch_pc = RESET_PC;
    endtask

    task automatic idle_inputs();
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.inst_take   = 1'b0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        #2;
        check("rst_imem_req",   32'(bus.imem_req),   32'd0);
        check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_inst_out",   bus.inst_out,        32'd0);
        check("rst_pc_out",     bus.pc_out,          32'd0);
        check("rst_npc_out",    bus.npc_out,         32'd4);
        check("rst_imem_addr",  bus.imem_addr,       RESET_PC);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Streaming with single-cycle memory and a consumer that always takes.
        run_phase(20, 100, 100, 100, 0);
        // Consumer stalled: the buffer fills, then drains in order.
        run_phase(12, 100, 100, 0, 0);
        run_phase(12, 100, 100, 100, 0);
        // Variable latency, occasional redirects.
        run_phase(600, 70, 50, 60, 5);
        // Heavy redirects, including back-to-back ones with responses in flight.
        run_phase(400, 90, 40, 50, 30);
        // Fast memory, slow consumer.
        run_phase(400, 100, 90, 20, 3);

        // Asynchronous reset mid-stream with the buffer partially full.
        run_phase(6, 100, 30, 0, 0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        idle_inputs();
        #1;
        check("midrst_imem_req",   32'(bus.imem_req),   32'd0);
        check("midrst_inst_valid", 32'(bus.inst_valid), 32'd0);
        // A late response from before the reset arrives while reset is still held.
        @(posedge clock);
        #1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        @(posedge clock);
        #1;
        bus.imem_rvalid = 1'b0;
        reset = 1'b0;
        model_reset();
        #4;
        check("post_rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("post_rst_imem_addr",  bus.imem_addr,       RESET_PC);

        run_phase(600, 80, 60, 70, 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
